// File: rtl/apb_bridge_multi.sv
// AHB-to-APB bridge: decodes NUM_SLV contiguous APB regions, with APB wait
// states, slave/decode error responses and a Pready timeout abort.
// Ports: AHB slave side (Hclk, Hreset, Hwrite, Hreadyin, Htrans, Haddr,
//   Hwdata, Hreadyout, Hresp, Hrdata); APB master side (Pselx, Paddr,
//   Pwdata, Pwrite, Penable, Prdata, Pready, Pslverr), one slice per slave.
module apb_bridge_multi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_SLV = 3,
  parameter logic [ADDR_W-1:0] SLV_BASE = 32'h8000_0000,
  parameter int SLV_SIZE_LOG2 = 26,
  parameter int TIMEOUT = 16
) (
  input  logic                      Hclk,
  input  logic                      Hreset,
  input  logic                      Hwrite,
  input  logic                      Hreadyin,
  input  logic [1:0]                Htrans,
  input  logic [ADDR_W-1:0]         Haddr,
  input  logic [DATA_W-1:0]         Hwdata,
  input  logic [NUM_SLV*DATA_W-1:0] Prdata,
  input  logic [NUM_SLV-1:0]        Pready,
  input  logic [NUM_SLV-1:0]        Pslverr,
  output logic [NUM_SLV-1:0]        Pselx,
  output logic [ADDR_W-1:0]         Paddr,
  output logic [DATA_W-1:0]         Pwdata,
  output logic                      Pwrite,
  output logic                      Penable,
  output logic                      Hreadyout,
  output logic [1:0]                Hresp,
  output logic [DATA_W-1:0]         Hrdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t r_state, w_next;
  logic [2:0] r_idx;
  logic [CW-1:0] r_cnt;

  logic [ADDR_W-1:0] w_off, w_region;
  logic w_hit, w_req, w_acc, w_tmo;
  logic [2:0] w_idx;
  logic w_pready, w_perr;
  logic [DATA_W-1:0] w_prdata;
  logic [CW-1:0] w_cnt_nxt;
  logic w_unused;

  assign w_unused = Htrans[0];

  // Region number relative to the base; below-base addresses wrap high.
  assign w_off = Haddr - SLV_BASE;
  assign w_region = w_off >> SLV_SIZE_LOG2;
  assign w_hit = (Haddr >= SLV_BASE) && (w_region < ADDR_W'(NUM_SLV));
  assign w_idx = w_region[2:0];

  always_comb begin
    w_pready = 1'b0;
    w_perr = 1'b0;
    w_prdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == 3'(i)) begin
        w_pready = Pready[i];
        w_perr = Pslverr[i];
        w_prdata = Prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
  // Abort on the cycle the low-Pready count reaches TIMEOUT.
  assign w_tmo = (TIMEOUT != 0) && (r_state == S_ACCESS) && !w_pready
                 && (w_cnt_nxt == CW'(TIMEOUT));

  assign w_req = Hreadyin && Htrans[1];
  assign w_acc = w_req && ((r_state == S_IDLE) || (r_state == S_ERR2) ||
                 ((r_state == S_ACCESS) && w_pready && !w_perr));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_ERR2: begin
        if (w_acc) w_next = !w_hit ? S_ERR1 : (Hwrite ? S_WDATA : S_SETUP);
        else w_next = S_IDLE;
      end
      S_WDATA: w_next = S_SETUP;
      S_SETUP: w_next = S_ACCESS;
      S_ACCESS: begin
        if (w_pready) begin
          if (w_perr) w_next = S_ERR2;
          else if (w_acc) w_next = !w_hit ? S_ERR1 :
                                   (Hwrite ? S_WDATA : S_SETUP);
          else w_next = S_IDLE;
        end else if (w_tmo) begin
          w_next = S_ERR2;
        end
      end
      S_ERR1: w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Pselx = '0;
    Penable = 1'b0;
    Hreadyout = 1'b1;
    Hresp = 2'b00;
    Hrdata = '0;
    if ((r_state == S_SETUP) || (r_state == S_ACCESS)) begin
      for (int i = 0; i < NUM_SLV; i++)
        if (r_idx == 3'(i)) Pselx[i] = 1'b1;
    end
    unique case (r_state)
      S_WDATA, S_SETUP: Hreadyout = 1'b0;
      S_ACCESS: begin
        Penable = 1'b1;
        Hrdata = w_prdata;
        Hreadyout = w_pready && !w_perr;
        if ((w_pready && w_perr) || w_tmo) Hresp = 2'b01;
      end
      S_ERR1: begin
        Hreadyout = 1'b0;
        Hresp = 2'b01;
      end
      S_ERR2: Hresp = 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_cnt <= '0;
      Paddr <= '0;
      Pwrite <= 1'b0;
      Pwdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_idx <= w_idx;
        Paddr <= Haddr;
        Pwrite <= Hwrite;
      end
      if (r_state == S_WDATA) Pwdata <= Hwdata;
      if (r_state == S_SETUP) r_cnt <= '0;
      else if ((r_state == S_ACCESS) && !w_pready) r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_apb_bridge_multi.sv
// Directed bench for apb_bridge_multi: reads, writes, wait states,
// slave/decode errors, timeout abort and reset mid-transfer.
module tb_apb_bridge_multi;

  logic Hclk = 1'b0;
  logic Hreset, Hwrite, Hreadyin;
  logic [1:0] Htrans;
  logic [31:0] Haddr, Hwdata;
  logic [95:0] Prdata;
  logic [2:0] Pready, Pslverr, Pselx;
  logic [31:0] Paddr, Pwdata, Hrdata;
  logic Pwrite, Penable, Hreadyout;
  logic [1:0] Hresp;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q[$];

  always #5 Hclk = ~Hclk;

  apb_bridge_multi dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .Pready(Pready), .Pslverr(Pslverr), .Pselx(Pselx), .Paddr(Paddr),
    .Pwdata(Pwdata), .Pwrite(Pwrite), .Penable(Penable),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
  );

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: scoreboard empty, got %h", tag, obs);
    end else begin
      e = q.pop_front();
      n_vec++;
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: got %h want %h", tag, obs, e);
      end
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic req(input logic w, input logic [31:0] a);
    Htrans = 2'b10;
    Hwrite = w;
    Haddr = a;
  endtask

  task automatic noreq();
    Htrans = 2'b00;
    Hwrite = 1'b0;
  endtask

  initial begin
    Hreset = 1'b1;
    Hwrite = 1'b0;
    Hreadyin = 1'b1;
    Htrans = 2'b00;
    Haddr = '0;
    Hwdata = '0;
    Prdata = {32'h2222_2222, 32'hCAFE_0001, 32'h1111_0000};
    Pready = 3'b111;
    Pslverr = 3'b000;
    step();
    step();
    Hreset = 1'b0;
    // reset values
    push(0); push(0); push(0); push(0); push(0); push(0); push(0); push(1);
    settle();
    chk("rst_psel", Pselx); chk("rst_pen", Penable);
    chk("rst_pwrite", Pwrite); chk("rst_paddr", Paddr);
    chk("rst_pwdata", Pwdata); chk("rst_hrdata", Hrdata);
    chk("rst_hresp", Hresp); chk("rst_hready", Hreadyout);

    // zero-wait read of slave 1
    step();
    req(1'b0, 32'h8400_0010);
    push(1); settle(); chk("rd_acc_hready", Hreadyout);
    step(); noreq();
    push(3'b010); push(0); push(0);
    settle();
    chk("rd_setup_psel", Pselx); chk("rd_setup_pen", Penable);
    chk("rd_setup_hready", Hreadyout);
    step();
    push(3'b010); push(1); push(32'hCAFE_0001); push(0); push(1);
    push(32'h8400_0010);
    settle();
    chk("rd_acc_psel", Pselx); chk("rd_acc_pen", Penable);
    chk("rd_hrdata", Hrdata); chk("rd_hresp", Hresp);
    chk("rd_hreadyout", Hreadyout); chk("rd_paddr", Paddr);
    step();
    push(0); push(0); settle();
    chk("rd_idle_psel", Pselx); chk("rd_idle_hrdata", Hrdata);

    // write slave 2, then back-to-back read slave 0
    step();
    req(1'b1, 32'h8800_0004);
    settle();
    step(); noreq();
    Hwdata = 32'hA5A5_A5A5;
    push(0); push(0); settle();
    chk("wr_wdata_hready", Hreadyout); chk("wr_wdata_psel", Pselx);
    step();
    Hwdata = 32'h0;
    push(3'b100); push(1); push(32'h8800_0004); push(0);
    settle();
    chk("wr_setup_psel", Pselx); chk("wr_setup_pwrite", Pwrite);
    chk("wr_setup_paddr", Paddr); chk("wr_setup_pen", Penable);
    step();
    req(1'b0, 32'h8000_0000);
    push(1); push(32'hA5A5_A5A5); push(1); push(1); push(3'b100);
    settle();
    chk("wr_acc_pen", Penable); chk("wr_acc_pwdata", Pwdata);
    chk("wr_acc_pwrite", Pwrite); chk("wr_acc_hready", Hreadyout);
    chk("wr_acc_psel", Pselx);
    step(); noreq();
    push(3'b001); push(0); push(0); push(32'h8000_0000);
    settle();
    chk("raw_setup_psel", Pselx); chk("raw_setup_pwrite", Pwrite);
    chk("raw_setup_pen", Penable); chk("raw_setup_paddr", Paddr);
    step();
    push(32'h1111_0000); push(1); settle();
    chk("raw_hrdata", Hrdata); chk("raw_hready", Hreadyout);
    step();

    // read slave 0 with three wait states
    req(1'b0, 32'h8000_0020);
    settle();
    step(); noreq();
    settle();
    for (int i = 0; i < 4; i++) begin
      step();
      Pready = (i < 3) ? 3'b110 : 3'b111;
      push((i < 3) ? 32'd0 : 32'd1); push(1); push(32'h8000_0020);
      push(3'b001);
      settle();
      chk("ws_hready", Hreadyout); chk("ws_pen", Penable);
      chk("ws_paddr", Paddr); chk("ws_psel", Pselx);
    end
    step();
    push(0); push(0); settle();
    chk("ws_done_psel", Pselx); chk("ws_done_pen", Penable);

    // slave error from slave 2
    req(1'b0, 32'h8800_0000);
    settle();
    step(); noreq();
    settle();
    step();
    Pslverr = 3'b100;
    push(1); push(0); settle();
    chk("se_hresp", Hresp); chk("se_hready", Hreadyout);
    step();
    Pslverr = 3'b000;
    push(1); push(1); push(0); settle();
    chk("se2_hresp", Hresp); chk("se2_hready", Hreadyout);
    chk("se2_psel", Pselx);
    step();
    push(0); push(1); settle();
    chk("se_idle_hresp", Hresp); chk("se_idle_hready", Hreadyout);

    // decode error
    req(1'b0, 32'h9000_0000);
    settle();
    step(); noreq();
    push(0); push(1); push(0); settle();
    chk("de1_psel", Pselx); chk("de1_hresp", Hresp); chk("de1_hready", Hreadyout);
    step();
    push(0); push(1); push(1); settle();
    chk("de2_psel", Pselx); chk("de2_hresp", Hresp); chk("de2_hready", Hreadyout);
    step();
    push(0); push(1); settle();
    chk("de_idle_hresp", Hresp); chk("de_idle_hready", Hreadyout);

    // timeout: Pready held low
    req(1'b0, 32'h8000_0000);
    settle();
    step(); noreq();
    Pready = 3'b000;
    settle();
    for (int i = 1; i <= 16; i++) begin
      step();
      push((i == 16) ? 32'd1 : 32'd0); push(0); push(1); push(3'b001);
      settle();
      chk("to_hresp", Hresp); chk("to_hready", Hreadyout);
      chk("to_pen", Penable); chk("to_psel", Pselx);
    end
    step();
    push(0); push(0); push(1); push(1); settle();
    chk("to_err2_psel", Pselx); chk("to_err2_pen", Penable);
    chk("to_err2_hresp", Hresp); chk("to_err2_hready", Hreadyout);
    step();
    Pready = 3'b111;
    push(0); settle(); chk("to_idle_hresp", Hresp);

    // Hreadyin low: request ignored
    req(1'b0, 32'h8400_0000);
    Hreadyin = 1'b0;
    settle();
    step(); noreq();
    Hreadyin = 1'b1;
    push(0); push(1); settle();
    chk("hrdyin_psel", Pselx); chk("hrdyin_hready", Hreadyout);

    // reset during ACCESS
    req(1'b0, 32'h8400_0000);
    settle();
    step(); noreq();
    Pready = 3'b000;
    settle();
    step();
    Hreset = 1'b1;
    push(1); settle(); chk("rr_pen_before", Penable);
    step();
    Hreset = 1'b0;
    push(0); push(0); push(0); push(0); push(1); push(0); push(0);
    settle();
    chk("rr_psel", Pselx); chk("rr_pen", Penable); chk("rr_paddr", Paddr);
    chk("rr_hresp", Hresp); chk("rr_hready", Hreadyout);
    chk("rr_hrdata", Hrdata); chk("rr_pwrite", Pwrite);
    Pready = 3'b111;
    step();

    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $error("FAIL sb_leftover: got %0d entries want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
